// File: rtl/range_counter.sv
// Bounded MIN_VAL..MAX_VAL up/down counter with wrap, clamped load, terminal count; 1 clk latency.
// Define RANGE_CNT_SATURATE_EN to hold at the bounds (sets sat) instead of wrapping.
module range_counter #(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = 18,
  parameter int MAX_VAL = 27,
  parameter int WRAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              load_err,
  output logic              sat
);

  localparam logic [WIDTH-1:0] MIN_V = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];

  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && (WIDTH >= 31 || MAX_VAL < (1 << WIDTH)))) begin : g_param_check
    $error("range_counter: require 0 <= MIN_VAL < MAX_VAL < 2**WIDTH");
  end

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic             hold_nxt;
  logic             at_bound;

  assign at_bound = up ? (count == MAX_V) : (count == MIN_V);
  assign tc       = en & at_bound;

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    hold_nxt  = 1'b0;
    if (load) begin
      if (load_val < MIN_V) begin
        count_nxt = MIN_V;
        err_nxt   = 1'b1;
      end else if (load_val > MAX_V) begin
        count_nxt = MAX_V;
        err_nxt   = 1'b1;
      end else begin
        count_nxt = load_val;
      end
    end else if (en) begin
      if (at_bound) begin
`ifdef RANGE_CNT_SATURATE_EN
        hold_nxt  = 1'b1;
`else
        count_nxt = up ? MIN_V : MAX_V;
        wrap_nxt  = 1'b1;
`endif
      end else begin
        count_nxt = up ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= MIN_V;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      wrap     <= wrap_nxt;
      wrap_cnt <= wrap_cnt + WRAP_W'(wrap_nxt);
      load_err <= err_nxt;
    end
  end

`ifdef RANGE_CNT_SATURATE_EN
  // sat reflects the last edge: set when en held the count at a bound, cleared otherwise
  always_ff @(posedge clk) begin
    if (rst) sat <= 1'b0;
    else     sat <= hold_nxt;
  end
`else
  assign sat = 1'b0;
  logic unused_hold;
  assign unused_hold = hold_nxt;
`endif

endmodule
